// File: rtl/rv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
//   mdu_op_t      : RV32M funct3 encodings
//   mdu_state_t   : control FSM states
//   MDU_ITER      : number of radix-2 iterations (one per CALC cycle)
//   MDU_CNT_W     : iteration counter width
//   DIV_BY_ZERO_Q : quotient returned for a zero divisor
//   INT_MIN       : most negative 32-bit value (signed-overflow operand)
package rv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINAL,
        DONE
    } mdu_state_t;

    localparam int          MDU_ITER      = 32;
    localparam int          MDU_CNT_W     = $clog2(MDU_ITER);
    localparam logic [31:0] DIV_BY_ZERO_Q = '1;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Fixed latency: START sampled at a posedge, BUSY for 33 cycles, then a
// one-cycle DONE pulse with RESULT valid.
// Ports:
//   CLK        : clock, all state changes on posedge
//   RST        : synchronous active-low reset
//   START      : request, sampled only in IDLE or DONE
//   FUNCT3     : RV32M operation select
//   OPERAND_A  : rs1 value
//   OPERAND_B  : rs2 value
//   DEST_REG   : rd index
//   BUSY       : operation in progress
//   DONE       : one-cycle completion pulse
//   RESULT     : result word, held until the next completion
//   RESULT_REG : rd index of the completed operation
//   RESULT_WEN : register-file write enable (DONE and rd != 0)
module mul_div_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_ADD_WIDTH = 5
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     START,
    input  logic [2:0]               FUNCT3,
    input  logic [DATA_WIDTH-1:0]    OPERAND_A,
    input  logic [DATA_WIDTH-1:0]    OPERAND_B,
    input  logic [REG_ADD_WIDTH-1:0] DEST_REG,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [DATA_WIDTH-1:0]    RESULT,
    output logic [REG_ADD_WIDTH-1:0] RESULT_REG,
    output logic                     RESULT_WEN
);
    import rv_pkg::*;

    localparam int DW = DATA_WIDTH;

    mdu_state_t               state_q, state_d;
    logic [MDU_CNT_W-1:0]     cnt_q;
    // Shared accumulator: multiply keeps {product_hi, multiplier/product_lo},
    // divide keeps {partial remainder, dividend/quotient}.
    logic [2*DW-1:0]          acc_q;
    logic [DW-1:0]            opb_q;      // multiplicand / divisor magnitude
    logic [DW-1:0]            opa_q;      // raw rs1, returned by REM on divide-by-zero
    mdu_op_t                  op_q;
    logic                     neg_q;      // result must be negated in FINAL
    logic                     b_zero_q;
    logic                     ovf_q;
    logic [REG_ADD_WIDTH-1:0] dest_q;
    logic [DW-1:0]            result_q;
    logic [REG_ADD_WIDTH-1:0] result_reg_q;

    logic accept;
    assign accept = START && ((state_q == IDLE) || (state_q == rv_pkg::DONE));

    // ---------------- operand capture ----------------
    mdu_op_t       op_in;
    logic          neg_a, neg_b, neg_in;
    logic [DW-1:0] mag_a, mag_b;

    always_comb begin
        op_in  = mdu_op_t'(FUNCT3);
        neg_a  = OPERAND_A[DW-1] &&
                 (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        neg_b  = OPERAND_B[DW-1] &&
                 (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
        mag_a  = neg_a ? -OPERAND_A : OPERAND_A;
        mag_b  = neg_b ? -OPERAND_B : OPERAND_B;
        // REM follows the dividend sign; MULHSU has neg_b=0 so the XOR covers it.
        neg_in = (op_in == OP_REM) ? neg_a : (neg_a ^ neg_b);
    end

    // ---------------- one radix-2 step ----------------
    logic [DW:0]     mul_sum;
    logic [DW:0]     div_shift;
    logic [DW:0]     div_diff;
    logic [2*DW-1:0] acc_step;

    always_comb begin
        // Shift-add: conditionally add multiplicand to the high half, then
        // shift the whole {carry, hi, lo} right by one.
        mul_sum   = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        // Restoring divide: bring in the next dividend bit, trial subtract.
        div_shift = {acc_q[2*DW-1:DW], acc_q[DW-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        if (op_q[2]) begin
            if (!div_diff[DW]) begin
                acc_step = {div_diff[DW-1:0], acc_q[DW-2:0], 1'b1};
            end else begin
                acc_step = {div_shift[DW-1:0], acc_q[DW-2:0], 1'b0};
            end
        end else begin
            acc_step = {mul_sum, acc_q[DW-1:1]};
        end
    end

    // ---------------- result selection ----------------
    logic [2*DW-1:0] prod_fix;
    logic [DW-1:0]   quot, rem, final_res;

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quot     = acc_q[DW-1:0];
        rem      = acc_q[2*DW-1:DW];
        case (op_q)
            OP_MUL:  final_res = prod_fix[DW-1:0];
            OP_DIV:  final_res = b_zero_q ? DIV_BY_ZERO_Q :
                                 ovf_q    ? INT_MIN :
                                 neg_q    ? -quot : quot;
            OP_DIVU: final_res = b_zero_q ? DIV_BY_ZERO_Q : quot;
            OP_REM:  final_res = b_zero_q ? opa_q :
                                 ovf_q    ? '0 :
                                 neg_q    ? -rem : rem;
            OP_REMU: final_res = b_zero_q ? opa_q : rem;
            default: final_res = prod_fix[2*DW-1:DW];   // MULH, MULHSU, MULHU
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = START ? CALC : IDLE;
            CALC:  state_d = (cnt_q == MDU_CNT_W'(MDU_ITER - 1)) ? FINAL : CALC;
            FINAL: state_d = rv_pkg::DONE;
            default: state_d = START ? CALC : IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        BUSY       = (state_q == CALC) || (state_q == FINAL);
        DONE       = (state_q == rv_pkg::DONE);
        RESULT_WEN = (state_q == rv_pkg::DONE) && (result_reg_q != '0);
        RESULT     = result_q;
        RESULT_REG = result_reg_q;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            opb_q        <= '0;
            opa_q        <= '0;
            op_q         <= OP_MUL;
            neg_q        <= 1'b0;
            b_zero_q     <= 1'b0;
            ovf_q        <= 1'b0;
            dest_q       <= '0;
            result_q     <= '0;
            result_reg_q <= '0;
        end else if (accept) begin
            cnt_q    <= '0;
            acc_q    <= {{DW{1'b0}}, mag_a};
            opb_q    <= mag_b;
            opa_q    <= OPERAND_A;
            op_q     <= op_in;
            neg_q    <= neg_in;
            b_zero_q <= (OPERAND_B == '0);
            ovf_q    <= (OPERAND_A == INT_MIN) && (OPERAND_B == '1);
            dest_q   <= DEST_REG;
        end else if (state_q == CALC) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + MDU_CNT_W'(1);
        end else if (state_q == FINAL) begin
            result_q     <= final_res;
            result_reg_q <= dest_q;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic [2:0]  FUNCT3 = 3'd0;
    logic [31:0] OPERAND_A = 32'd0;
    logic [31:0] OPERAND_B = 32'd0;
    logic [4:0]  DEST_REG = 5'd0;
    logic        BUSY, DONE, RESULT_WEN;
    logic [31:0] RESULT;
    logic [4:0]  RESULT_REG;

    int total = 0;
    int bad   = 0;

    mul_div_unit #(.DATA_WIDTH(32), .REG_ADD_WIDTH(5)) dut (
        .CLK(CLK), .RST(RST), .START(START), .FUNCT3(FUNCT3),
        .OPERAND_A(OPERAND_A), .OPERAND_B(OPERAND_B), .DEST_REG(DEST_REG),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT),
        .RESULT_REG(RESULT_REG), .RESULT_WEN(RESULT_WEN)
    );

    always #5 CLK = ~CLK;

    // Reference model straight from the RV32M definitions, using 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            4: return 32'($urandom_range(0, 100)) - 32'd50;
            default: return $urandom;
        endcase
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Presents an operation with START for one cycle; returns in cycle 1.
    task automatic issue(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        FUNCT3 = f; OPERAND_A = a; OPERAND_B = b; DEST_REG = rd;
        START = 1'b1;
        step();
        START = 1'b0;
    endtask

    // Advances until DONE (bounded); reports the cycle DONE was seen in (-1 on
    // timeout) and how many cycles BUSY was wrong.
    task automatic wait_done(input int start_cyc, output int cyc, output int busy_bad);
        cyc = start_cyc;
        busy_bad = 0;
        while (DONE !== 1'b1 && cyc < 60) begin
            if (BUSY !== 1'b1) busy_bad++;
            step();
            cyc++;
        end
        if (DONE !== 1'b1) cyc = -1;
        else if (BUSY !== 1'b0) busy_bad++;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        step(); step();
        total++;
        if ({BUSY, DONE, RESULT_WEN} !== 3'b000 || RESULT !== 32'd0 || RESULT_REG !== 5'd0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%0b done=%0b wen=%0b result=%h reg=%0d, required all zero",
                     BUSY, DONE, RESULT_WEN, RESULT, RESULT_REG);
        end
        RST = 1'b1;
        step();
        total++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%0b done=%0b, required 0 0", BUSY, DONE);
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_mul_basic();
        int cyc, bb;
        issue(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5);
        wait_done(1, cyc, bb);
        total++;
        if (cyc !== 34 || bb !== 0) begin
            bad++;
            $display("FAIL mul_latency: done_cycle=%0d busy_errors=%0d, required 34 0", cyc, bb);
        end
        total++;
        if (RESULT !== 32'hFFFF_FFEB || RESULT_REG !== 5'd5 || RESULT_WEN !== 1'b1) begin
            bad++;
            $display("FAIL mul_result: result=%h reg=%0d wen=%0b, required ffffffeb 5 1",
                     RESULT, RESULT_REG, RESULT_WEN);
        end
        $display("mul 7*-3: cycle=%0d result=%h reg=%0d", cyc, RESULT, RESULT_REG);
        step();
        total++;
        if (DONE !== 1'b0 || RESULT_WEN !== 1'b0 || RESULT !== 32'hFFFF_FFEB) begin
            bad++;
            $display("FAIL after_done: done=%0b wen=%0b result=%h, required 0 0 ffffffeb",
                     DONE, RESULT_WEN, RESULT);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  fv [11] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd4, 3'd7, 3'd4, 3'd6, 3'd5};
        logic [31:0] av [11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5,
                                 32'h8000_0000, 32'h8000_0000, 32'd5};
        logic [31:0] bv [11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                                 32'd2, 32'd2, 32'd0, 32'd0,
                                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] ev [11] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD,
                                 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 32'd5,
                                 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
        int cyc, bb;
        for (int i = 0; i < 11; i++) begin
            issue(fv[i], av[i], bv[i], 5'(i + 1));
            wait_done(1, cyc, bb);
            total++;
            if (cyc !== 34 || bb !== 0 || RESULT !== ev[i]) begin
                bad++;
                $display("FAIL directed_%0d: f=%0d a=%h b=%h cycle=%0d busy_errors=%0d result=%h, required cycle 34 result %h",
                         i, fv[i], av[i], bv[i], cyc, bb, RESULT, ev[i]);
            end
            $display("directed %0d: f=%0d a=%h b=%h result=%h", i, fv[i], av[i], bv[i], RESULT);
            step();
        end
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b, exp;
        logic [4:0]  rd;
        int cyc, bb;
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            rd = 5'($urandom_range(0, 31));
            exp = ref_model(f, a, b);
            issue(f, a, b, rd);
            // Scramble inputs: the captured operation must be unaffected.
            FUNCT3 = 3'($urandom); OPERAND_A = $urandom; OPERAND_B = $urandom; DEST_REG = 5'($urandom);
            wait_done(1, cyc, bb);
            total++;
            if (cyc !== 34 || bb !== 0 || RESULT !== exp || RESULT_REG !== rd ||
                RESULT_WEN !== (rd != 5'd0)) begin
                bad++;
                $display("FAIL random_%0d: f=%0d a=%h b=%h cycle=%0d busy_errors=%0d result=%h reg=%0d wen=%0b, required result %h reg %0d",
                         i, f, a, b, cyc, bb, RESULT, RESULT_REG, RESULT_WEN, exp, rd);
            end
            $display("random %0d: f=%0d a=%h b=%h rd=%0d result=%h", i, f, a, b, rd, RESULT);
            if ($urandom_range(0, 1) == 1) step();
        end
    endtask

    task automatic test_start_ignored();
        int cyc, bb;
        issue(3'd4, 32'd100, 32'd7, 5'd9);
        for (int i = 1; i < 10; i++) step();
        issue(3'd0, 32'd3, 32'd3, 5'd4);   // START in cycle 10, must be ignored
        wait_done(11, cyc, bb);
        total++;
        if (cyc !== 34 || bb !== 0 || RESULT !== 32'd14 || RESULT_REG !== 5'd9) begin
            bad++;
            $display("FAIL start_while_busy: cycle=%0d busy_errors=%0d result=%h reg=%0d, required 34 0 0000000e 9",
                     cyc, bb, RESULT, RESULT_REG);
        end
        $display("start ignored: cycle=%0d result=%h", cyc, RESULT);
        step();
        total++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            bad++;
            $display("FAIL no_second_op: busy=%0b done=%0b, required 0 0", BUSY, DONE);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bb;
        logic [31:0] exp2;
        exp2 = ref_model(3'd2, 32'hDEAD_BEEF, 32'h1234_5678);
        issue(3'd7, 32'd1000, 32'd7, 5'd3);
        wait_done(1, cyc, bb);
        total++;
        if (cyc !== 34 || RESULT !== 32'd6) begin
            bad++;
            $display("FAIL b2b_first: cycle=%0d result=%h, required 34 00000006", cyc, RESULT);
        end
        issue(3'd2, 32'hDEAD_BEEF, 32'h1234_5678, 5'd7);  // START held in the DONE cycle
        wait_done(1, cyc, bb);
        total++;
        if (cyc !== 34 || bb !== 0 || RESULT !== exp2 || RESULT_REG !== 5'd7) begin
            bad++;
            $display("FAIL b2b_second: cycle=%0d busy_errors=%0d result=%h reg=%0d, required 34 0 %h 7",
                     cyc, bb, RESULT, RESULT_REG, exp2);
        end
        $display("back to back: second result=%h cycle=%0d", RESULT, cyc);
        step();
    endtask

    task automatic test_rd_zero();
        int cyc, bb;
        issue(3'd3, 32'h8000_0000, 32'h0000_0004, 5'd0);
        wait_done(1, cyc, bb);
        total++;
        if (cyc !== 34 || DONE !== 1'b1 || RESULT_WEN !== 1'b0 || RESULT !== 32'd2) begin
            bad++;
            $display("FAIL rd_zero: cycle=%0d done=%0b wen=%0b result=%h, required 34 1 0 00000002",
                     cyc, DONE, RESULT_WEN, RESULT);
        end
        $display("rd zero: done=%0b wen=%0b result=%h", DONE, RESULT_WEN, RESULT);
        step();
    endtask

    task automatic test_reset_mid();
        int cyc, bb, seen;
        issue(3'd0, 32'd12, 32'd12, 5'd2);
        for (int i = 1; i < 15; i++) step();
        RST = 1'b0;                        // low during cycle 15
        step();
        RST = 1'b1;
        total++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || RESULT !== 32'd0 || RESULT_REG !== 5'd0) begin
            bad++;
            $display("FAIL mid_reset: busy=%0b done=%0b result=%h reg=%0d, required 0 0 00000000 0",
                     BUSY, DONE, RESULT, RESULT_REG);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (DONE === 1'b1 || BUSY === 1'b1) seen++;
            step();
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL aborted_op: active_cycles=%0d, required 0", seen);
        end
        issue(3'd0, 32'd12, 32'd12, 5'd2);
        wait_done(1, cyc, bb);
        total++;
        if (cyc !== 34 || bb !== 0 || RESULT !== 32'd144 || RESULT_WEN !== 1'b1) begin
            bad++;
            $display("FAIL after_reset_op: cycle=%0d busy_errors=%0d result=%h wen=%0b, required 34 0 00000090 1",
                     cyc, bb, RESULT, RESULT_WEN);
        end
        $display("mid reset: recovered result=%h", RESULT);
        step();
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_directed();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_rd_zero();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
